// File: rtl/emmc_ddr_block_rx.sv
// Receive-side data-block engine for 4-bit DDR eMMC.
// It waits for the start bit, then unpacks one block into 16-bit words.
// It checks the eight per-line CRC16 streams and the end bit, then reports status.
module emmc_ddr_block_rx #(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  rd_pos,
    input  logic [3:0]  rd_neg,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        crc_err,
    output logic [7:0]  crc_err_lines,
    output logic        end_err,
    output logic        timeout_err
);

    localparam int DataW    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DataW-1:0]    DataLast    = DataW'(BLOCK_BYTES - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]         CrcPoly     = 16'h1021;

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END} rxState_t;

    rxState_t              state;
    rxState_t              nextState;
    logic [DataW-1:0]      dataCnt;
    logic [3:0]            crcCnt;
    logic [TimeoutW-1:0]   timeoutCnt;
    logic [15:0]           crcPos [4];
    logic [15:0]           crcNeg [4];
    logic [3:0]            highPos;
    logic [3:0]            highNeg;
    logic                  startAccept;

    // One serial CRC16-CCITT step, MSB first
    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic bitIn);
        crcStep = {crc[14:0], 1'b0} ^ ((crc[15] ^ bitIn) ? CrcPoly : 16'h0000);
    endfunction

    assign startAccept = (state == IDLE) && start && !abort;
    assign busy        = (state != IDLE);
    assign crc_err     = |crc_err_lines;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic; abort returns any active state to IDLE
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startAccept) nextState = WAIT_START;
            end
            WAIT_START: begin
                if (abort)                          nextState = IDLE;
                else if (rd_pos == 4'b0000)         nextState = DATA;
                else if (timeoutCnt == TimeoutLast) nextState = IDLE;
            end
            DATA: begin
                if (abort)                    nextState = IDLE;
                else if (dataCnt == DataLast) nextState = CRC;
            end
            CRC: begin
                if (abort)                nextState = IDLE;
                else if (crcCnt == 4'd15) nextState = END;
            end
            END: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: counters, word assembly, CRC accumulation/compare and status flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            done          <= 1'b0;
            crc_err_lines <= '0;
            end_err       <= 1'b0;
            timeout_err   <= 1'b0;
            dataCnt       <= '0;
            crcCnt        <= '0;
            timeoutCnt    <= '0;
            highPos       <= '0;
            highNeg       <= '0;
            for (int i = 0; i < 4; i++) begin
                crcPos[i] <= '0;
                crcNeg[i] <= '0;
            end
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (startAccept) begin
                        crc_err_lines <= '0;
                        end_err       <= 1'b0;
                        timeout_err   <= 1'b0;
                        dataCnt       <= '0;
                        crcCnt        <= '0;
                        timeoutCnt    <= '0;
                        for (int i = 0; i < 4; i++) begin
                            crcPos[i] <= '0;
                            crcNeg[i] <= '0;
                        end
                    end
                end
                WAIT_START: begin
                    if (!abort) begin
                        if (rd_pos == 4'b0000)              dataCnt     <= '0;
                        else if (timeoutCnt == TimeoutLast) timeout_err <= 1'b1;
                        else                                timeoutCnt  <= timeoutCnt + TimeoutW'(1);
                    end
                end
                DATA: begin
                    if (!abort) begin
                        for (int i = 0; i < 4; i++) begin
                            crcPos[i] <= crcStep(crcPos[i], rd_pos[i]);
                            crcNeg[i] <= crcStep(crcNeg[i], rd_neg[i]);
                        end
                        if (!dataCnt[0]) begin
                            highPos <= rd_pos;
                            highNeg <= rd_neg;
                        end else begin
                            rx_data  <= {highPos, rd_pos, highNeg, rd_neg};
                            rx_valid <= 1'b1;
                        end
                        if (dataCnt != DataLast) dataCnt <= dataCnt + DataW'(1);
                    end
                end
                CRC: begin
                    if (!abort) begin
                        for (int i = 0; i < 4; i++) begin
                            crc_err_lines[i]     <= crc_err_lines[i]     | (rd_pos[i] ^ crcPos[i][15]);
                            crc_err_lines[i + 4] <= crc_err_lines[i + 4] | (rd_neg[i] ^ crcNeg[i][15]);
                            crcPos[i] <= {crcPos[i][14:0], 1'b0};
                            crcNeg[i] <= {crcNeg[i][14:0], 1'b0};
                        end
                        if (crcCnt != 4'd15) crcCnt <= crcCnt + 4'd1;
                    end
                end
                END: begin
                    if (!abort) begin
                        end_err <= (rd_pos != 4'b1111);
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/emmc_ddr_block_rx.md
# emmc_ddr_block_rx

Receive-side data-block engine for the eMMC host controller in 4-bit DDR mode. Consumes the per-line rising/falling-edge samples produced by the four DAT-line DDR I/O cells, detects the start bit, deserializes one data block into 16-bit words, checks the two CRC16s per line and the end bit, and reports status to the host-controller FSM.

## Interface
- BLOCK_BYTES, 512, bytes per block; even, ≥2
- TIMEOUT_CYCLES, 1024, max Clk cycles waiting for the start bit after arming
- Clk  in  1  controller clock, same clock driving the DAT I/O cells
- Reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse: arm reception of one block; ignored while busy
- abort  in  1  synchronous abort; returns to IDLE, no done pulse
- rd_pos  in  4  DAT[3:0] rising-edge samples for this cycle
- rd_neg  in  4  DAT[3:0] falling-edge samples for this cycle (aligned with rd_pos)
- rx_data  out  16  {byte 2k, byte 2k+1}
- rx_valid  out  1  one-cycle pulse, rx_data valid; no backpressure
- busy  out  1  high from the cycle after accepted start until done/timeout/abort
- done  out  1  one-cycle pulse, block finished (end bit checked)
- crc_err  out  1  any CRC mismatch in last block; held until next accepted start
- crc_err_lines  out  8  [3:0] rising-edge CRC mismatch per line, [7:4] falling-edge
- end_err  out  1  end bit not 4'b1111; held until next accepted start
- timeout_err  out  1  start bit not seen within TIMEOUT_CYCLES; held until next accepted start

## Operation
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE: start=1 -> WAIT_START, clear all error flags and 8 CRC registers (init 0x0000), clear counters.
- WAIT_START: rd_pos==4'b0000 -> DATA. Timeout counter increments each cycle; reaching TIMEOUT_CYCLES without start bit -> timeout_err=1, IDLE. Partial-zero start (some lines 0, some 1) is not a start bit.
- DATA: BLOCK_BYTES cycles, 8 bits/cycle. Pair of cycles A,B: A carries high nibbles (rd_pos=byte0[7:4], rd_neg=byte1[7:4]); B carries low nibbles (rd_pos=byte0[3:0], rd_neg=byte1[3:0]). Word = {A.pos, B.pos, A.neg, B.neg}. Per line i, crc_pos[i] absorbs rd_pos[i], crc_neg[i] absorbs rd_neg[i]; CRC16-CCITT x^16+x^12+x^5+1, MSB first, no final XOR.
- CRC: 16 cycles; rd_pos[i]/rd_neg[i] carry received CRC bit 15 down to 0 for crc_pos[i]/crc_neg[i]. Each bit compared with computed CRC MSB, computed register shifts left; any mismatch sets the matching crc_err_lines bit (sticky). crc_err = |crc_err_lines.
- END: rd_pos!=4'b1111 -> end_err=1. Next state IDLE; done pulses.
- abort in any non-IDLE state: IDLE next cycle, busy low, no done, no rx_valid for incomplete pair; error flags keep current values.
- start coincident with abort: abort wins. start while busy: ignored.
- Counters: data counter $clog2(BLOCK_BYTES) bits, CRC counter 4 bits, timeout counter $clog2(TIMEOUT_CYCLES+1) bits; no wrap within a block.

## Timing
- Reset values: rx_data=0, rx_valid=0, busy=0, done=0, crc_err=0, crc_err_lines=0, end_err=0, timeout_err=0; state IDLE. Reset mid-block discards everything, no done.
- start accepted in cycle t -> busy=1 from t+1.
- Start bit sampled in cycle s -> data cycles s+1..s+BLOCK_BYTES, CRC cycles s+BLOCK_BYTES+1..s+BLOCK_BYTES+16, end cycle e=s+BLOCK_BYTES+17.
- rx_valid registered: asserted in the cycle after each B cycle; BLOCK_BYTES/2 pulses per block, the last at s+BLOCK_BYTES+1.
- done, busy=0, and final crc_err/crc_err_lines/end_err all visible in cycle e+1. New start accepted from e+1.
- Timeout: armed at t, no start bit -> timeout_err=1, busy=0 in cycle t+1+TIMEOUT_CYCLES.

## Test plan
- All-zero block, CRCs 0x0000 on all 8 streams, end 4'b1111 -> 256 rx_valid pulses, rx_data=0x0000, done at e+1, all error flags 0.
- Bytes 0x00..0xFF twice, model-computed CRCs -> words 0x0001,0x0203,...,0xFEFF in order, crc_err=0, start bit at s gives first rx_valid at s+3.
- Same block, received CRC bit 7 of falling-edge stream on line 2 inverted -> crc_err=1, crc_err_lines=8'b0100_0000, data still delivered, done pulses.
- End bit 4'b1011 -> end_err=1, crc_err=0, done pulses.
- Armed, DAT held 4'b1111 (and one cycle of 4'b0101) for 1024 cycles -> timeout_err=1, busy=0 at t+1025, no done.
- abort at data cycle 101, then Reset asserted during a second block's CRC phase -> IDLE each time, no done, only 50 rx_valid pulses for first block, all outputs at reset values after Reset.
